btn_conditioner: RTL and testbench

- Front-end input stage for the pong renderer. Takes the raw, bouncy, asynchronous push-buttons (4) and slide switches (2) from the board.
- Produces clean, synchronised, debounced levels that drive the renderer's btns, auto and background inputs directly.
- Also produces single-cycle press, release and auto-repeat strobes for menu or score logic.
- Runs in the 125 MHz pclk domain, the same domain as the renderer.

---
 rtl/btn_cond_pkg.sv | 46 ++++
 rtl/btn_cond_if.sv | 39 +++
 rtl/btn_conditioner_debounce_ch.sv | 57 +++++
 rtl/btn_conditioner.sv | 134 +++++++++++++
 tb/tb_btn_conditioner.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/btn_cond_pkg.sv
// Shared types and default constants for the button conditioner.
// Imported by the interface, the debounce channel and the top.
package btn_cond_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  localparam int DEF_N_BTN             = 4;
  localparam int DEF_N_SW              = 2;
  localparam int DEF_DEBOUNCE_CYC      = 1250000;
  localparam int DEF_REPEAT_DELAY_CYC  = 62500000;
  localparam int DEF_REPEAT_PERIOD_CYC = 12500000;
  localparam int DEF_CNT_W             = 27;

  localparam int SW_AUTO = 0;
  localparam int SW_BG   = 1;

  typedef struct packed {
    logic stable;
    logic rise;
    logic fall;
  } ch_out_t;

  function automatic longint max3(
    input longint a,
    input longint b,
    input longint c
  );
    longint m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  function automatic bit cnt_fits(
    input int     w,
    input longint m
  );
    return (longint'(1) << w) > m;
  endfunction

endpackage

// File: rtl/btn_cond_if.sv
// Raw board inputs and conditioned levels/strobes of the button conditioner.
// master drives the raw inputs, slave is the conditioner itself.
interface btn_cond_if #(
  parameter int N_BTN = 4,
  parameter int N_SW  = 2
);

  logic [N_BTN-1:0] btn_raw;
  logic [N_SW-1:0]  sw_raw;
  logic [N_BTN-1:0] btns;
  logic             auto;
  logic             background;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_repeat;

  modport master (
    output btn_raw,
    output sw_raw,
    input  btns,
    input  auto,
    input  background,
    input  btn_press,
    input  btn_release,
    input  btn_repeat
  );

  modport slave (
    input  btn_raw,
    input  sw_raw,
    output btns,
    output auto,
    output background,
    output btn_press,
    output btn_release,
    output btn_repeat
  );

endinterface

// File: rtl/btn_conditioner_debounce_ch.sv
// One input channel: 2-flop synchroniser, debounce counter,
// stable level and registered rise/fall strobes.
module debounce_ch
  import btn_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic    pclk,
  input  logic    reset_n,
  input  logic    raw,
  output ch_out_t ch
);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic             prev;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      prev   <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      prev  <= stable;
      rise  <= stable & ~prev;
      fall  <= ~stable & prev;
      // any sample agreeing with stable restarts the hold window
      if (sync2 != stable) begin
        if (cnt == CNT_MAX) begin
          stable <= sync2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign ch = '{stable: stable, rise: rise, fall: fall};

endmodule

// File: rtl/btn_conditioner.sv
// Button/switch front end: debounced levels, press/release
// strobes and per-button auto-repeat strobes in the pclk domain.
module btn_conditioner
  import btn_cond_pkg::*;
#(
  parameter int N_BTN             = DEF_N_BTN,
  parameter int N_SW              = DEF_N_SW,
  parameter int DEBOUNCE_CYC      = DEF_DEBOUNCE_CYC,
  parameter int REPEAT_DELAY_CYC  = DEF_REPEAT_DELAY_CYC,
  parameter int REPEAT_PERIOD_CYC = DEF_REPEAT_PERIOD_CYC,
  parameter int CNT_W             = DEF_CNT_W
) (
  input logic       pclk,
  input logic       reset_n,
  btn_cond_if.slave io
);

  localparam int N_CH = N_BTN + N_SW;

  localparam logic [CNT_W-1:0] DLY_MAX =
    CNT_W'(REPEAT_DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] PER_MAX =
    CNT_W'(REPEAT_PERIOD_CYC - 1);

  if (!cnt_fits(CNT_W, max3(DEBOUNCE_CYC,
                            REPEAT_DELAY_CYC,
                            REPEAT_PERIOD_CYC))) begin : g_chk_cnt_w
    $error("CNT_W too narrow for the cycle parameters");
  end

  if (DEBOUNCE_CYC < 1 || REPEAT_DELAY_CYC < 1 ||
      REPEAT_PERIOD_CYC < 1) begin : g_chk_cyc
    $error("cycle parameters must be at least 1");
  end

  if (N_SW <= SW_BG) begin : g_chk_sw
    $error("N_SW must cover the auto and background switches");
  end

  logic [N_CH-1:0]  raw_all;
  ch_out_t          ch [N_CH];
  logic [N_BTN-1:0] btn_stable;
  logic [N_BTN-1:0] btn_rise;
  logic [N_BTN-1:0] btn_fall;
  logic [N_BTN-1:0] btn_rpt;
  logic [N_SW-1:0]  sw_stable;

  assign raw_all = {io.sw_raw, io.btn_raw};

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .CNT_W       (CNT_W)
    ) u_ch (
      .pclk   (pclk),
      .reset_n(reset_n),
      .raw    (raw_all[i]),
      .ch     (ch[i])
    );
  end

  for (genvar b = 0; b < N_BTN; b++) begin : g_btn
    assign btn_stable[b] = ch[b].stable;
    assign btn_rise[b]   = ch[b].rise;
    assign btn_fall[b]   = ch[b].fall;
  end

  for (genvar s = 0; s < N_SW; s++) begin : g_sw
    logic edge_unused;
    assign sw_stable[s] = ch[N_BTN+s].stable;
    assign edge_unused  = ch[N_BTN+s].rise |
                          ch[N_BTN+s].fall;
  end

  for (genvar b = 0; b < N_BTN; b++) begin : g_rpt
    rpt_state_e       st;
    logic [CNT_W-1:0] rcnt;
    logic             rep;

    // IDLE only ever sees stable=1 on the cycle the press
    // strobe is registered; stable=0 wins over any pulse.
    always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
        st   <= IDLE;
        rcnt <= '0;
        rep  <= 1'b0;
      end else begin
        rep <= 1'b0;
        if (!btn_stable[b]) begin
          st   <= IDLE;
          rcnt <= '0;
        end else begin
          unique case (st)
            IDLE: begin
              st   <= DELAY;
              rcnt <= '0;
            end
            DELAY: begin
              if (rcnt == DLY_MAX) begin
                rep  <= 1'b1;
                rcnt <= '0;
                st   <= REPEAT;
              end else begin
                rcnt <= rcnt + 1'b1;
              end
            end
            REPEAT: begin
              if (rcnt == PER_MAX) begin
                rep  <= 1'b1;
                rcnt <= '0;
              end else begin
                rcnt <= rcnt + 1'b1;
              end
            end
            default: begin
              st   <= IDLE;
              rcnt <= '0;
            end
          endcase
        end
      end
    end

    assign btn_rpt[b] = rep;
  end

  assign io.btns        = btn_stable;
  assign io.btn_press   = btn_rise;
  assign io.btn_release = btn_fall;
  assign io.btn_repeat  = btn_rpt;
  assign io.auto        = sw_stable[SW_AUTO];
  assign io.background  = sw_stable[SW_BG];

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios plus random
// bouncing inputs, every cycle compared with a window-based model.
module tb_btn_conditioner;

  localparam int NB  = 4;
  localparam int NS  = 2;
  localparam int NC  = NB + NS;
  localparam int DEB = 8;
  localparam int DLY = 20;
  localparam int PER = 5;
  localparam int CW  = 6;

  logic pclk    = 1'b0;
  logic reset_n = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  btn_cond_if #(.N_BTN(NB), .N_SW(NS)) bus ();

  btn_conditioner #(
    .N_BTN            (NB),
    .N_SW             (NS),
    .DEBOUNCE_CYC     (DEB),
    .REPEAT_DELAY_CYC (DLY),
    .REPEAT_PERIOD_CYC(PER),
    .CNT_W            (CW)
  ) dut (
    .pclk   (pclk),
    .reset_n(reset_n),
    .io     (bus.slave)
  );

  always #4 pclk = ~pclk;

  // model state
  bit           m_s1  [NC];
  bit           m_s2  [NC];
  bit [DEB-1:0] m_win [NC];
  bit           m_st  [NC];
  bit           m_pst [NC];
  bit           m_pr  [NC];
  bit           m_rl  [NC];
  bit           m_rp  [NB];
  int           m_age [NB];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s got=%0h exp=%0h cyc=%0d",
                 tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < NC; c++) begin
      m_s1[c]  = 0;
      m_s2[c]  = 0;
      m_win[c] = '0;
      m_st[c]  = 0;
      m_pst[c] = 0;
      m_pr[c]  = 0;
      m_rl[c]  = 0;
    end
    for (int b = 0; b < NB; b++) begin
      m_rp[b]  = 0;
      m_age[b] = 0;
    end
  endtask

  // stable flips once the last DEB synchronised samples all
  // disagree with it; repeats fire at held ages DLY+1+k*PER
  task automatic model_step(input logic [NB-1:0] b,
                            input logic [NS-1:0] s);
    bit [DEB-1:0] ones;
    bit [DEB-1:0] zero;
    ones = '1;
    zero = '0;
    for (int c = 0; c < NC; c++) begin
      bit raw;
      bit old;
      if (c < NB) raw = b[c];
      else        raw = s[c-NB];
      old      = m_st[c];
      m_win[c] = {m_win[c][DEB-2:0], m_s2[c]};
      if (m_win[c] == (old ? zero : ones)) m_st[c] = ~old;
      m_pr[c]  = old & ~m_pst[c];
      m_rl[c]  = ~old & m_pst[c];
      m_pst[c] = old;
      if (c < NB) begin
        if (old) m_age[c]++;
        else     m_age[c] = 0;
        m_rp[c] = old && (m_age[c] > DLY) &&
                  ((m_age[c] - DLY - 1) % PER == 0);
      end
      m_s2[c] = m_s1[c];
      m_s1[c] = raw;
    end
  endtask

  task automatic compare_all();
    logic [NB-1:0] eb, ep, er, erp;
    for (int b = 0; b < NB; b++) begin
      eb[b]  = m_st[b];
      ep[b]  = m_pr[b];
      er[b]  = m_rl[b];
      erp[b] = m_rp[b];
    end
    chk("btns",        bus.btns,        eb);
    chk("btn_press",   bus.btn_press,   ep);
    chk("btn_release", bus.btn_release, er);
    chk("btn_repeat",  bus.btn_repeat,  erp);
    chk("auto",        bus.auto,        m_st[NB+0]);
    chk("background",  bus.background,  m_st[NB+1]);
  endtask

  task automatic run_cycle();
    @(posedge pclk);
    if (reset_n) model_step(bus.btn_raw, bus.sw_raw);
    else         model_clear();
    cyc++;
    @(negedge pclk);
    compare_all();
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_btns",    bus.btns,        0);
    chk("rst_press",   bus.btn_press,   0);
    chk("rst_release", bus.btn_release, 0);
    chk("rst_repeat",  bus.btn_repeat,  0);
    chk("rst_auto",    bus.auto,        0);
    chk("rst_bg",      bus.background,  0);
    model_clear();
    run_cycle();
    run_cycle();
    reset_n = 1'b1;
  endtask

  initial begin
    int lat, plat, npr, nrep, nrel;
    int rise_c, first_rep, press_c, fall_c, rep_on_rel;
    bus.btn_raw = '0;
    bus.sw_raw  = '0;
    model_clear();
    run_cycle();
    run_cycle();
    @(negedge pclk);
    pulse_reset();

    // clean press on btn 0
    bus.btn_raw[0] = 1'b1;
    lat  = -1;
    plat = -1;
    for (int k = 1; k <= 14; k++) begin
      run_cycle();
      if (lat < 0 && bus.btns[0])       lat  = k;
      if (plat < 0 && bus.btn_press[0]) plat = k;
    end
    chk("s1_btns_lat",  lat,  DEB + 2);
    chk("s1_press_lat", plat, DEB + 3);

    // bouncing btn 1
    npr = 0;
    for (int t = 0; t < 10; t++) begin
      bus.btn_raw[1] = ~bus.btn_raw[1];
      for (int k = 0; k < 3; k++) begin
        run_cycle();
        if (bus.btn_press[1]) npr++;
      end
    end
    bus.btn_raw[1] = 1'b1;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      run_cycle();
      if (lat < 0 && bus.btns[1]) lat = k;
      if (bus.btn_press[1]) npr++;
    end
    chk("s2_btns_lat", lat, DEB + 2);
    chk("s2_presses",  npr, 1);

    // auto-repeat and release on btn 2
    bus.btn_raw[2] = 1'b1;
    rise_c = -1; press_c = -1; first_rep = -1; fall_c = -1;
    nrep = 0; nrel = 0; rep_on_rel = 0;
    for (int k = 1; k <= 100; k++) begin
      run_cycle();
      if (rise_c < 0 && bus.btns[2]) rise_c = k;
      if (press_c < 0 && bus.btn_press[2]) press_c = k;
      if (bus.btn_repeat[2]) begin
        nrep++;
        if (first_rep < 0) first_rep = k;
      end
      if (bus.btn_release[2]) begin
        nrel++;
        if (bus.btn_repeat[2]) rep_on_rel++;
      end
      if (rise_c > 0 && fall_c < 0 && k > rise_c &&
          !bus.btns[2]) fall_c = k;
      if (rise_c > 0 && k == rise_c + 50)
        bus.btn_raw[2] = 1'b0;
    end
    chk("s3_first_rep", first_rep - press_c, DLY);
    chk("s3_repeats",   nrep,                8);
    chk("s3_releases",  nrel,                1);
    chk("s3_fall_lat",  fall_c - rise_c,     60);
    chk("s3_rep_on_rel", rep_on_rel,         0);

    // switches
    bus.sw_raw = 2'b10;
    lat = -1;
    npr = 0;
    for (int k = 1; k <= 15; k++) begin
      run_cycle();
      if (lat < 0 && bus.background) lat = k;
      npr += $countones(bus.btn_press | bus.btn_release);
    end
    chk("s4_bg_lat",  lat,      DEB + 2);
    chk("s4_auto",    bus.auto, 0);
    chk("s4_strobes", npr,      0);

    // reset while btn 3 is repeating
    bus.btn_raw[3] = 1'b1;
    for (int k = 0; k < 40; k++) run_cycle();
    chk("s5_held", bus.btns[3], 1);
    pulse_reset();
    lat  = -1;
    plat = -1;
    for (int k = 1; k <= 14; k++) begin
      run_cycle();
      if (lat < 0 && bus.btns[3])       lat  = k;
      if (plat < 0 && bus.btn_press[3]) plat = k;
    end
    chk("s5_btns_lat",  lat,  DEB + 2);
    chk("s5_press_lat", plat, DEB + 3);

    // random bouncing in segments of varying activity
    for (int seg = 0; seg < 15; seg++) begin
      int p;
      case ($urandom_range(2))
        0:       p = 1;
        1:       p = 5;
        default: p = 25;
      endcase
      for (int k = 0; k < 200; k++) begin
        for (int i = 0; i < NB; i++)
          if ($urandom_range(99) < p)
            bus.btn_raw[i] = ~bus.btn_raw[i];
        for (int i = 0; i < NS; i++)
          if ($urandom_range(99) < p / 2 + 1)
            bus.sw_raw[i] = ~bus.sw_raw[i];
        if ($urandom_range(999) == 0) pulse_reset();
        run_cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
